sd_modulator: RTL

//  Transmit-side counterpart of the channel input path: converts a stream of signed

---
 rtl/sd_modulator.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sd_modulator.sv
// -----------------------------------------------------------------------------
// sd_modulator
//   Second-order digital sigma-delta modulator. Turns a stream of signed
//   parallel samples into a 1-bit bitstream DSDOUT and its bit clock SDCLK,
//   which is derived from SYSCLK. Samples enter through a one-deep buffer
//   with a valid/ready handshake. Each sample is held for reg_osr+1 bits.
//
// Ports
//   SYSCLK        in   system clock
//   SYSRST        in   asynchronous reset, active-high
//   reg_en        in   modulator enable
//   reg_clkdiv    in   SDCLK half-period = reg_clkdiv+1 SYSCLK cycles
//   reg_osr       in   bits per sample = reg_osr+1
//   sample_data   in   signed input sample (DATA_W bits)
//   sample_valid  in   sample_data valid
//   sample_ready  out  buffer can accept a sample
//   DSDOUT        out  sigma-delta bitstream, updated on SDCLK falling edge
//   SDCLK         out  bit clock; DSDOUT is stable around its rising edge
//   underrun      out  sticky: a new sample was needed while the buffer was empty
// -----------------------------------------------------------------------------
module sd_modulator #(
    parameter int DATA_W  = 16,
    parameter int GUARD_W = 4
) (
    input  logic              SYSCLK,
    input  logic              SYSRST,
    input  logic              reg_en,
    input  logic [3:0]        reg_clkdiv,
    input  logic [7:0]        reg_osr,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              DSDOUT,
    output logic              SDCLK,
    output logic              underrun
);

    localparam int IW = DATA_W + GUARD_W;  // integrator width
    localparam int SW = IW + 2;            // headroom for the unsaturated sums

    // Feedback magnitude 2^(DATA_W-1), expressed at sum width.
    localparam logic signed [SW-1:0] FS =
        {{(SW-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};

    // Clamp a wide sum to the IW-bit signed range. This keeps a full-scale
    // negative input from wrapping the integrator sign.
    function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] hi;
        logic signed [SW-1:0] lo;
        hi = {{(SW-IW+1){1'b0}}, {(IW-1){1'b1}}};
        lo = {{(SW-IW+1){1'b1}}, {(IW-1){1'b0}}};
        if (v > hi)
            return hi[IW-1:0];
        else if (v < lo)
            return lo[IW-1:0];
        else
            return v[IW-1:0];
    endfunction

    function automatic logic signed [SW-1:0] ext_iw(input logic signed [IW-1:0] v);
        return {{(SW-IW){v[IW-1]}}, v};
    endfunction

    logic [3:0]               div_cnt;
    logic [7:0]               bit_cnt;
    logic                     sdclk_r;
    logic                     dsdout_r;
    logic                     underrun_r;
    logic                     buf_full;
    logic signed [DATA_W-1:0] buf_data;
    logic signed [DATA_W-1:0] active;
    logic signed [IW-1:0]     int1;
    logic signed [IW-1:0]     int2;

    logic                     tick;
    logic                     step;
    logic                     wrap;
    logic                     take;
    logic                     y;
    logic signed [SW-1:0]     x_w;
    logic signed [SW-1:0]     fb;
    logic signed [SW-1:0]     sum1;
    logic signed [SW-1:0]     sum2;
    logic signed [IW-1:0]     int1_nxt;
    logic signed [IW-1:0]     int2_nxt;

    assign sample_ready = ~buf_full & ~SYSRST;
    assign take         = sample_valid & sample_ready;

    // ">=" rather than "==" so that lowering reg_clkdiv below the current
    // count still ends the half-period, instead of running on to a 4-bit wrap.
    assign tick = reg_en & (div_cnt >= reg_clkdiv);
    // A modulator step happens on the cycle where SDCLK falls.
    assign step = tick & sdclk_r;
    assign wrap = (bit_cnt == reg_osr);

    // Modulator step. The output bit comes from the pre-update int2.
    always_comb begin
        y        = ~int2[IW-1];
        x_w      = {{(SW-DATA_W){active[DATA_W-1]}}, active};
        fb       = y ? FS : -FS;
        sum1     = ext_iw(int1) + x_w - fb;
        int1_nxt = sat(sum1);
        sum2     = ext_iw(int2) + ext_iw(int1_nxt) - fb;
        int2_nxt = sat(sum2);
    end

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sdclk_r    <= 1'b0;
            dsdout_r   <= 1'b0;
            underrun_r <= 1'b0;
            buf_full   <= 1'b0;
            active     <= '0;
            int1       <= '0;
            int2       <= '0;
        end else begin
            // Reload at the wrap step. The next step then uses the new sample.
            if (step && wrap) begin
                if (buf_full) begin
                    active   <= buf_data;
                    buf_full <= 1'b0;
                end else begin
                    underrun_r <= 1'b1;
                end
            end
            // Ready is only high when the buffer is empty, so the reload
            // above cannot collide with a transfer. A transfer wins if both
            // happen on the same edge.
            if (take)
                buf_full <= 1'b1;

            if (!reg_en) begin
                div_cnt  <= '0;
                bit_cnt  <= '0;
                sdclk_r  <= 1'b0;
                dsdout_r <= 1'b0;
                int1     <= '0;
                int2     <= '0;
            end else begin
                if (tick) begin
                    div_cnt <= '0;
                    sdclk_r <= ~sdclk_r;
                end else begin
                    div_cnt <= div_cnt + 4'd1;
                end
                if (step) begin
                    dsdout_r <= y;
                    int1     <= int1_nxt;
                    int2     <= int2_nxt;
                    bit_cnt  <= wrap ? 8'd0 : bit_cnt + 8'd1;
                end
            end
        end
    end

    // Buffer payload: its validity is carried by buf_full, so it needs no reset.
    always_ff @(posedge SYSCLK) begin
        if (take)
            buf_data <= sample_data;
    end

    assign SDCLK    = sdclk_r;
    assign DSDOUT   = dsdout_r;
    assign underrun = underrun_r;

endmodule
